display_timing_recover_480p: RTL and testbench

Receive-side counterpart of the 640x480p60 timing generator. Samples an incoming hsync/vsync/de stream in the pixel clock domain and recovers the pixel position (sx, sy). Checks active width, line period and active line count against nominal values, and runs a lock state machine that asserts `locked` only after consecutive clean frames. Sits at the front of any sink that consumes a raw DVI/VGA-style stream, such as capture or overlay logic.

---
 rtl/display_timing_recover_480p.sv | 195 +++++++++++++++++++
 tb/tb_display_timing_recover_480p.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_recover_480p.sv
// display_timing_recover_480p
//
// Recovers the pixel position from a raw DVI/VGA-style hsync/vsync/de stream
// in the pixel clock domain. The block checks the active width, the line
// period and the active line count against nominal values. A lock state
// machine asserts `locked` only after LOCK_FRAMES consecutive clean frames.
//
// Ports:
//   clk_pix      pixel clock, the only clock
//   rst          asynchronous, active-high reset
//   hsync        horizontal sync (negative polarity); registered only, not used
//   vsync        vertical sync (negative polarity)
//   de           data enable, high on active pixels
//   sx           horizontal position of the sample taken on the previous edge
//   sy           active-line index within the frame
//   de_o         de delayed to line up with sx/sy
//   line_start   pulse when sx==0
//   frame_start  pulse when sx==0 and sy==0
//   locked       sx/sy are trustworthy
//   timing_err   single-cycle pulse on a failed check while not searching

module display_timing_recover_480p #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       de_o,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
  localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
  localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);
  localparam logic [2:0]  LOCK_W     = 3'(LOCK_FRAMES);

  logic        de_q;
  logic        vsync_q;
  logic        hsync_q;
  logic        unused_hsync;
  logic        de_rise;
  logic        de_fall;
  logic        vs_fall;
  logic        boundary;
  logic [10:0] sx_inc;
  logic [10:0] sy_inc;
  logic        width_err;
  logic        period_err;
  logic        count_err;
  logic        any_err;
  logic [1:0]  state;
  logic        vs_seen;
  logic        armed;
  logic        frame_bad;
  logic [2:0]  good_cnt;
  logic [2:0]  good_next;

  // One-cycle delayed copies of the inputs. They reset to the idle levels,
  // so the first sample after reset cannot look like an edge.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      de_q    <= 1'b0;
      vsync_q <= 1'b1;
      hsync_q <= 1'b1;
    end else begin
      de_q    <= de;
      vsync_q <= vsync;
      hsync_q <= hsync;
    end
  end

  assign unused_hsync = hsync_q;
  assign de_o         = de_q;

  assign de_rise  = de & ~de_q;
  assign de_fall  = ~de & de_q;
  assign vs_fall  = ~vsync & vsync_q;
  assign boundary = de_rise & vs_seen;

  // The "+1" forms are 11 bits wide. This keeps a saturated counter (1023)
  // from wrapping to 0 and passing a check by accident.
  assign sx_inc = {1'b0, sx} + 11'd1;
  assign sy_inc = {1'b0, sy} + 11'd1;

  // The checks look at the register values before this cycle's update.
  // sx+1 is the number of clocks since the last de rise.
  assign width_err  = de_fall & (sx_inc != H_ACTIVE_W);
  assign period_err = de_rise & ~vs_seen & (sx_inc != H_TOTAL_W);
  assign count_err  = boundary & armed & (sy_inc != V_ACTIVE_W);
  assign any_err    = width_err | period_err | count_err;

  assign good_next = good_cnt + 3'd1;

  // Position recovery. A de rise that coincides with a vsync fall still
  // belongs to the old frame, because it uses the old vs_seen value.
  // vs_seen is set only after that rise has been handled.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx          <= 10'd0;
      sy          <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vs_seen     <= 1'b0;
    end else begin
      line_start  <= de_rise;
      frame_start <= boundary;
      if (de_rise) begin
        sx <= 10'd0;
      end else if (sx != 10'h3FF) begin
        sx <= sx + 10'd1;
      end
      if (de_rise) begin
        if (vs_seen) begin
          sy <= 10'd0;
        end else if (sy != 10'h3FF) begin
          sy <= sy_inc[9:0];
        end
      end
      if (vs_fall) begin
        vs_seen <= 1'b1;
      end else if (de_rise) begin
        vs_seen <= 1'b0;
      end
    end
  end

  // Lock state machine. The first frame boundary after leaving SEARCH only
  // arms the line-count check, because the frame it closes was never fully
  // observed. Each later clean boundary counts toward lock.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state      <= ST_SEARCH;
      armed      <= 1'b0;
      good_cnt   <= 3'd0;
      frame_bad  <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      case (state)
        ST_SEARCH: begin
          armed     <= 1'b0;
          good_cnt  <= 3'd0;
          frame_bad <= 1'b0;
          if (vs_fall) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (any_err) begin
            timing_err <= 1'b1;
            frame_bad  <= 1'b1;
            state      <= ST_SEARCH;
          end else if (boundary) begin
            frame_bad <= 1'b0;
            if (!armed) begin
              armed <= 1'b1;
            end else if (!frame_bad) begin
              good_cnt <= good_next;
              if (good_next == LOCK_W) begin
                state <= ST_LOCKED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (any_err) begin
            timing_err <= 1'b1;
            frame_bad  <= 1'b1;
            state      <= ST_SEARCH;
          end
        end
        default: begin
          state <= ST_SEARCH;
        end
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_display_timing_recover_480p.sv
// tb_display_timing_recover_480p
//
// Scoreboard bench for display_timing_recover_480p with a shrunk timing:
// 21 active pixels, 41-clock lines, 19 active lines and 29 lines per frame.
// The stimulus side generates frames and can inject faults into them. For
// each sample it drives, it pushes the reference model's expected outputs
// into a queue. The monitor pops one entry after every clock edge and
// compares it with the DUT outputs.

module tb_display_timing_recover_480p;

  localparam int H_ACTIVE    = 21;
  localparam int H_TOTAL     = 41;
  localparam int V_ACTIVE    = 19;
  localparam int LOCK_FRAMES = 2;
  localparam int V_TOTAL     = 29;
  localparam int VS_LINE     = 25;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de_o;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       timing_err;
  } out_t;

  logic       clk_pix;
  logic       rst;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de_o;
  logic       line_start;
  logic       frame_start;
  logic       locked;
  logic       timing_err;

  int   checks;
  int   errors;
  out_t exp_q[$];

  // Reference model state. Positions are derived from timestamps: the model
  // records the sample index of the last de rise and counts lines since the
  // last frame boundary. Lock progress is the number of clean boundaries
  // seen since leaving search.
  int m_n;
  int m_rise_t;
  int m_lines;
  bit m_pending;
  bit m_tracking;
  int m_bnd;
  bit m_prev_de;
  bit m_prev_vs;

  display_timing_recover_480p #(
    .H_ACTIVE   (H_ACTIVE),
    .H_TOTAL    (H_TOTAL),
    .V_ACTIVE   (V_ACTIVE),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .sx         (sx),
    .sy         (sy),
    .de_o       (de_o),
    .line_start (line_start),
    .frame_start(frame_start),
    .locked     (locked),
    .timing_err (timing_err)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  function automatic void model_reset();
    m_n        = 0;
    m_rise_t   = -1;
    m_lines    = 0;
    m_pending  = 1'b0;
    m_tracking = 1'b0;
    m_bnd      = 0;
    m_prev_de  = 1'b0;
    m_prev_vs  = 1'b1;
  endfunction

  function automatic out_t model_step(input bit de_v, input bit vs_v);
    out_t e;
    bit   rise;
    bit   fall;
    bit   vfall;
    bit   err;
    int   elapsed;
    int   pos;
    rise    = de_v && !m_prev_de;
    fall    = !de_v && m_prev_de;
    vfall   = !vs_v && m_prev_vs;
    elapsed = m_n - m_rise_t;
    err     = 1'b0;
    if (!m_tracking) begin
      if (vfall) begin
        m_tracking = 1'b1;
        m_bnd      = 0;
      end
    end else begin
      if (fall && elapsed != H_ACTIVE) err = 1'b1;
      if (rise && !m_pending && elapsed != H_TOTAL) err = 1'b1;
      if (rise && m_pending && m_bnd >= 1 && m_lines + 1 != V_ACTIVE) err = 1'b1;
      if (err) m_tracking = 1'b0;
      else if (rise && m_pending) m_bnd++;
    end
    e.frame_start = rise && m_pending;
    e.line_start  = rise;
    e.de_o        = de_v;
    e.timing_err  = err;
    if (rise) begin
      m_rise_t = m_n;
      if (m_pending) m_lines = 0;
      else m_lines++;
    end
    if (vfall) m_pending = 1'b1;
    else if (rise) m_pending = 1'b0;
    pos      = m_n - m_rise_t;
    e.sx     = 10'((pos > 1023) ? 1023 : pos);
    e.sy     = 10'((m_lines > 1023) ? 1023 : m_lines);
    e.locked = m_tracking && (m_bnd >= LOCK_FRAMES + 1);
    m_prev_de = de_v;
    m_prev_vs = vs_v;
    m_n++;
    return e;
  endfunction

  task automatic checkOutput(input out_t exp, input string name);
    out_t act;
    act = {sx, sy, de_o, line_start, frame_start, locked, timing_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got sx=%0d sy=%0d de_o=%b ls=%b fs=%b lk=%b err=%b, expected sx=%0d sy=%0d de_o=%b ls=%b fs=%b lk=%b err=%b",
               name, $time, act.sx, act.sy, act.de_o, act.line_start, act.frame_start,
               act.locked, act.timing_err, exp.sx, exp.sy, exp.de_o, exp.line_start,
               exp.frame_start, exp.locked, exp.timing_err);
    end
  endtask

  // Drives one sample at the falling edge and queues the model's prediction
  // for the outputs after the next rising edge.
  task automatic applyStimulus(input logic de_v, input logic vs_v, input logic hs_v);
    @(negedge clk_pix);
    de    = de_v;
    vsync = vs_v;
    hsync = hs_v;
    exp_q.push_back(model_step(de_v, vs_v));
  endtask

  task automatic assertReset(input int cycles);
    @(negedge clk_pix);
    rst   = 1'b1;
    de    = 1'b0;
    vsync = 1'b1;
    hsync = 1'b1;
    #1;
    checkOutput('0, "reset_async");
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_pix);
      exp_q.push_back('0);
    end
  endtask

  task automatic releaseReset();
    @(negedge clk_pix);
    rst   = 1'b0;
    de    = 1'b0;
    vsync = 1'b1;
    hsync = 1'b1;
    model_reset();
    exp_q.push_back(model_step(1'b0, 1'b1));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b1, 1'b1);
  endtask

  // One frame of V_TOTAL lines. Line bad_line uses bad_width instead of the
  // nominal width. vsync is low for lines vs_line and vs_line+1. A
  // non-negative abort_after cuts the frame short after that many samples.
  task automatic send_frame(input int n_act, input int period, input int bad_line,
                            input int bad_width, input int vs_line, input int abort_after);
    int  cnt;
    int  w;
    bit  d;
    bit  v;
    bit  h;
    cnt = 0;
    for (int y = 0; y < V_TOTAL; y++) begin
      w = (y == bad_line) ? bad_width : H_ACTIVE;
      for (int x = 0; x < period; x++) begin
        if (cnt == abort_after) return;
        d = (y < n_act) && (x < w);
        v = !(y == vs_line || y == vs_line + 1);
        h = !(x >= H_ACTIVE + 2 && x < H_ACTIVE + 6);
        applyStimulus(d, v, h);
        cnt++;
      end
    end
  endtask

  task automatic clean_frames(input int n);
    for (int i = 0; i < n; i++) send_frame(V_ACTIVE, H_TOTAL, -1, 0, VS_LINE, -1);
  endtask

  // Monitor: compares one queued expectation after every rising edge.
  initial begin
    forever begin
      @(posedge clk_pix);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), "stream");
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    de     = 1'b0;
    vsync  = 1'b1;
    hsync  = 1'b1;
    model_reset();

    assertReset(4);
    releaseReset();
    idle(30);

    // Clean stream: lock arrives at the third boundary after the first vsync.
    clean_frames(5);

    // One short line while locked: error on the de fall, then relock.
    send_frame(V_ACTIVE, H_TOTAL, int'($urandom_range(1, 17)), 20, VS_LINE, -1);
    clean_frames(4);

    // One frame with an extra active line: caught at the next boundary.
    send_frame(V_ACTIVE + 1, H_TOTAL, -1, 0, VS_LINE, -1);
    clean_frames(4);

    // Line period 42: error on the second de rise of each frame, no lock.
    send_frame(V_ACTIVE, H_TOTAL + 1, -1, 0, VS_LINE, -1);
    send_frame(V_ACTIVE, H_TOTAL + 1, -1, 0, VS_LINE, -1);
    clean_frames(4);

    // vsync falls on the same cycle as the last line's de rise.
    send_frame(V_ACTIVE, H_TOTAL, -1, 0, V_ACTIVE - 1, -1);
    clean_frames(1);

    // Randomized frames drawn from clean and faulty variants.
    for (int f = 0; f < 6; f++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        1: send_frame(V_ACTIVE, H_TOTAL, int'($urandom_range(0, 18)),
                      int'($urandom_range(15, 27)), VS_LINE, -1);
        2: send_frame(int'($urandom_range(17, 21)), H_TOTAL, -1, 0, VS_LINE, -1);
        3: send_frame(V_ACTIVE, int'($urandom_range(40, 43)), -1, 0, VS_LINE, -1);
        4: send_frame(V_ACTIVE, H_TOTAL, -1, 0, int'($urandom_range(18, 26)), -1);
        default: clean_frames(1);
      endcase
    end
    clean_frames(1);

    // Reset in the middle of a frame, then recover from scratch.
    send_frame(V_ACTIVE, H_TOTAL, -1, 0, VS_LINE, int'($urandom_range(50, 1100)));
    assertReset(3);
    releaseReset();
    idle(10);
    clean_frames(4);
    idle(5);

    @(negedge clk_pix);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
